bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial FSM stages. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single-bit stream `x`. That stream is sampled every cycle by the downstream serial state machine. A one-word holding buffer lets consecutive words stream with no gap bits.

---
 rtl/bit_serializer_pkg.sv | 17 +
 rtl/ser_shift_reg.sv | 57 +++++
 rtl/bit_serializer.sv | 173 +++++++++++++++++
 tb/tb_bit_serializer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg
//   Shared types and sizing helpers for the bit_serializer block.
//   ser_state_t : serializer FSM states.
//   SER_CNT_W   : width of bit counters/indices able to hold 0..width.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    function automatic int unsigned SER_CNT_W(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// ser_shift_reg
//   WIDTH-bit load/shift register with a down-counter that flags the last
//   data bit of the word currently being emitted.
//   Ports:
//     CLK, RESET  clock, asynchronous active-high reset
//     load        capture load_data (takes priority over shift)
//     load_data   word to capture
//     shift       advance to the next bit
//     bit_out     bit that will be current after this edge (lookahead), so
//                 the parent can register it straight into its output flop
//     last        the bit currently on the output is the word's final data bit
module ser_shift_reg
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             bit_out,
    output logic             last
);

    localparam int unsigned CW = SER_CNT_W(WIDTH);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load) begin
            sh_d  = load_data;
            cnt_d = CW'(WIDTH - 1);
        end else if (shift) begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    // sh_q[0] is the bit on the wire now; after a shift sh_q[1] takes its place.
    assign bit_out = load ? load_data[0] : sh_q[1];
    assign last    = (cnt_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial front end: accepts WIDTH-bit words on a valid/ready
//   handshake and emits them LSB first, one bit per clock, on x. A one-word
//   holding buffer allows back-to-back words with no gap bits.
//   Optional feature: define BIT_SERIALIZER_PARITY_EN to append one odd-parity
//   bit (~^word) after each word's data bits.
//   Ports:
//     CLK, RESET  clock, asynchronous active-high reset
//     in_data     word to serialise, sampled on an accepting edge
//     in_valid    in_data is valid
//     in_ready    a word can be accepted (holding buffer empty)
//     x           serial bit (registered)
//     x_valid     x carries a data/parity bit rather than idle fill
//     busy        shifter or holding buffer occupied
//     bit_idx     index of the bit on x (WIDTH for parity, 0 when idle)
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        x,
    output logic                        x_valid,
    output logic                        busy,
    output logic [SER_CNT_W(WIDTH)-1:0] bit_idx
);

    localparam int unsigned CW = SER_CNT_W(WIDTH);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic [CW-1:0]    idx_q, idx_d;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             accept;
    logic             shifter_free;
    logic             sr_load;
    logic             sr_shift;
    logic [WIDTH-1:0] sr_load_data;
    logic             sr_bit;
    logic             sr_last;

    assign in_ready = !hold_full_q;
    assign accept   = in_valid && !hold_full_q;

    ser_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (sr_load),
        .load_data (sr_load_data),
        .shift     (sr_shift),
        .bit_out   (sr_bit),
        .last      (sr_last)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        x_d          = IDLE_BIT;
        x_valid_d    = 1'b0;
        idx_d        = '0;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        shifter_free = 1'b0;
        // Oldest word first: the held word wins over one arriving this edge.
        sr_load_data = hold_full_q ? hold_q : in_data;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d        = par_q;
`endif

        unique case (state_q)
            IDLE: shifter_free = 1'b1;
            SHIFT: begin
                if (sr_last) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d = PARITY;
`else
                    shifter_free = 1'b1;
`endif
                end else begin
                    sr_shift = 1'b1;
                end
            end
            PARITY: shifter_free = 1'b1;
            default: state_d = IDLE;
        endcase

        if (shifter_free) begin
            if (hold_full_q || accept) begin
                sr_load = 1'b1;
                state_d = SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
                par_d   = ~^sr_load_data;
`endif
                // Held word moves to the shifter; a word accepted on the same
                // edge refills the buffer. With the buffer empty, it bypasses.
                hold_full_d = hold_full_q && accept;
                if (hold_full_q && accept) begin
                    hold_d = in_data;
                end
            end else begin
                state_d = IDLE;
            end
        end else if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        // Output flops are loaded with what the next state will present.
        unique case (state_d)
            SHIFT: begin
                x_d       = sr_bit;
                x_valid_d = 1'b1;
                idx_d     = sr_load ? '0 : idx_q + CW'(1);
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                x_d       = par_q;
                x_valid_d = 1'b1;
                idx_d     = CW'(WIDTH);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            x_q         <= IDLE_BIT;
            x_valid_q   <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            idx_q       <= idx_d;
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign bit_idx = idx_q;
    assign busy    = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

    localparam int unsigned W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         x;
    logic         x_valid;
    logic         busy;
    logic [3:0]   bit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] tx_q[$];
    logic         exp_bit[$];
    int           exp_idx[$];

    always #5 CLK = ~CLK;

    bit_serializer #(
        .WIDTH    (W),
        .IDLE_BIT (1'b0)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .x_valid  (x_valid),
        .busy     (busy),
        .bit_idx  (bit_idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_x"},        x,        0);
        check_eq({tag, "_x_valid"},  x_valid,  0);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_busy"},     busy,     0);
        check_eq({tag, "_bit_idx"},  bit_idx,  0);
    endtask

    task automatic add_word(input logic [W-1:0] w);
        tx_q.push_back(w);
        for (int i = 0; i < W; i++) begin
            exp_bit.push_back(w[i]);
            exp_idx.push_back(i);
        end
        if (PB != 0) begin
            exp_bit.push_back(~^w);
            exp_idx.push_back(W);
        end
    endtask

    // Starts at a negedge; offers queued words, holding each until in_ready.
    task automatic drive_words(output int stall);
        int guard;
        stall = 0;
        while (tx_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = tx_q.pop_front();
            guard    = 0;
            while (!in_ready && guard < 100) begin
                stall++;
                guard++;
                @(negedge CLK);
            end
            if (!in_ready) check_eq("ready_timeout", in_ready, 1);
            @(posedge CLK);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Every cycle from the first accepting edge must carry the next expected bit.
    task automatic expect_stream(input string tag);
        @(posedge CLK);
        while (exp_bit.size() > 0) begin
            @(negedge CLK);
            check_eq({tag, "_valid"}, x_valid, 1);
            check_eq({tag, "_x"},     x,       exp_bit.pop_front());
            check_eq({tag, "_idx"},   bit_idx, exp_idx.pop_front());
        end
        @(negedge CLK);
        check_eq({tag, "_end_valid"}, x_valid, 0);
        check_eq({tag, "_end_x"},     x,       0);
        check_eq({tag, "_end_busy"},  busy,    0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;

        // Reset and idle
        #2;
        check_idle("rst_held");
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_idle("idle");
        end

        // Single word
        add_word(8'hA5);
        fork
            drive_words(stall);
            expect_stream("single");
        join
        check_eq("single_stall", stall, 0);

        // Back-to-back words, no gap
        add_word(8'hA5);
        add_word(8'h3C);
        fork
            drive_words(stall);
            expect_stream("b2b");
        join
        check_eq("b2b_stall", stall, 0);

        // Three words: third stalls until the held word reaches the shifter
        add_word(8'hA5);
        add_word(8'h3C);
        add_word(8'hFF);
        fork
            drive_words(stall);
            expect_stream("three");
        join
        check_eq("three_stall", stall, W - 1 + PB);
        check_idle("three_after");

        // Reset mid-word with a word waiting in the holding buffer
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        fork
            drive_words(stall);
            begin
                @(posedge CLK);
                repeat (4) @(negedge CLK);
            end
        join
        check_eq("mid_x",        x,        0);
        check_eq("mid_idx",      bit_idx,  3);
        check_eq("mid_valid",    x_valid,  1);
        check_eq("mid_in_ready", in_ready, 0);
        check_eq("mid_busy",     busy,     1);
        #1;
        RESET = 1'b1;
        #1;
        check_idle("async_rst");
        @(negedge CLK);
        RESET = 1'b0;
        add_word(8'h01);
        fork
            drive_words(stall);
            expect_stream("post_rst");
        join
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_eq("no_stale_valid", x_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
